// File: rtl/vga_address_decoder_if.sv
// Request/response bus for the address-to-coordinate decoder.
// Widths follow the same RESOLUTION selection as the decoder itself.
interface vga_address_decoder_if #(
    parameter string RESOLUTION = "640x480"
);
    localparam bit IS_QVGA = (RESOLUTION == "320x240");
    localparam int XW = IS_QVGA ? 9 : 10;
    localparam int YW = IS_QVGA ? 8 : 9;
    localparam int AW = IS_QVGA ? 17 : 19;

    logic [AW-1:0] mem_address;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          err;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output mem_address, in_valid, out_ready,
        input  in_ready, x, y, err, out_valid
    );

    modport slave (
        input  mem_address, in_valid, out_ready,
        output in_ready, x, y, err, out_valid
    );
endinterface

// File: rtl/vga_address_decoder.sv
// Converts a linear frame-buffer address back to (x,y) using a restoring
// divider that resolves one quotient bit per clock.
module vga_address_decoder #(
    parameter string RESOLUTION = "640x480"
) (
    input  logic                  clock,
    input  logic                  reset,
    vga_address_decoder_if.slave  bus
);
    localparam bit IS_QVGA = (RESOLUTION == "320x240");
    localparam int WIDTH   = IS_QVGA ? 320 : 640;
    localparam int HEIGHT  = IS_QVGA ? 240 : 480;
    localparam int XW      = IS_QVGA ? 9 : 10;
    localparam int YW      = IS_QVGA ? 8 : 9;
    localparam int AW      = IS_QVGA ? 17 : 19;
    localparam int TOTAL   = WIDTH * HEIGHT;
    localparam int KW      = $clog2(YW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [AW-1:0] rem;
    logic [YW-1:0] quot;
    logic [KW-1:0] k;
    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic          err_reg;

    logic          addr_err;
    logic [AW:0]   divisor;
    logic          ge;
    logic [AW-1:0] diff;
    logic [AW-1:0] rem_next;
    logic [YW-1:0] quot_next;

    // Operands are widened by one bit so every compare stays unsigned.
    assign addr_err  = {1'b0, bus.mem_address} >= (AW+1)'(TOTAL);
    assign divisor   = (AW+1)'(WIDTH) << k;
    assign ge        = {1'b0, rem} >= divisor;
    assign diff      = rem - divisor[AW-1:0];
    assign rem_next  = ge ? diff : rem;

    always_comb begin
        quot_next = quot;
        if (ge) begin
            quot_next[k] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = addr_err ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (k == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Out-of-range addresses skip the divider and report err immediately.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem     <= '0;
            quot    <= '0;
            k       <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            err_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (addr_err) begin
                            err_reg <= 1'b1;
                            x_reg   <= '0;
                            y_reg   <= '0;
                        end else begin
                            rem     <= bus.mem_address;
                            quot    <= '0;
                            k       <= KW'(YW-1);
                            err_reg <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    rem  <= rem_next;
                    quot <= quot_next;
                    if (k == '0) begin
                        x_reg <= rem_next[XW-1:0];
                        y_reg <= quot_next;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.x   = x_reg;
    assign bus.y   = y_reg;
    assign bus.err = err_reg;
endmodule

// File: tb/tb_vga_address_decoder.sv
// Directed and randomized checks of vga_address_decoder in both resolutions.
module tb_vga_address_decoder;
    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;

    vga_address_decoder_if #(.RESOLUTION("640x480")) vga_bus ();
    vga_address_decoder_if #(.RESOLUTION("320x240")) qvga_bus ();

    vga_address_decoder #(.RESOLUTION("640x480")) dut_vga (
        .clock (clock),
        .reset (reset),
        .bus   (vga_bus)
    );

    vga_address_decoder #(.RESOLUTION("320x240")) dut_qvga (
        .clock (clock),
        .reset (reset),
        .bus   (qvga_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one request from a falling edge and waits for out_valid; lat counts edges after the accept edge.
    task automatic applyStimulus(input bit qvga, input logic [18:0] addr, output int lat,
                                 output logic [9:0] ox, output logic [8:0] oy, output logic oerr);
        if (qvga) begin
            qvga_bus.mem_address = addr[16:0];
            qvga_bus.in_valid    = 1'b1;
        end else begin
            vga_bus.mem_address = addr;
            vga_bus.in_valid    = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
        vga_bus.in_valid  = 1'b0;
        qvga_bus.in_valid = 1'b0;
        lat = 0;
        while (!(qvga ? qvga_bus.out_valid : vga_bus.out_valid) && lat < 40) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
        ox   = qvga ? {1'b0, qvga_bus.x} : vga_bus.x;
        oy   = qvga ? {1'b0, qvga_bus.y} : vga_bus.y;
        oerr = qvga ? qvga_bus.err : vga_bus.err;
    endtask

    task automatic consumeResult(input bit qvga);
        if (qvga) qvga_bus.out_ready = 1'b1;
        else      vga_bus.out_ready  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        vga_bus.out_ready  = 1'b0;
        qvga_bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        vga_bus.mem_address = 19'd5;
        vga_bus.in_valid    = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset            = 1'b0;
        vga_bus.in_valid = 1'b0;
        tests_run++;
        if (vga_bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready got %b expected 1", vga_bus.in_ready);
        end
        tests_run++;
        if (vga_bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid got %b expected 0", vga_bus.out_valid);
        end
        tests_run++;
        if (vga_bus.x !== 10'd0 || vga_bus.y !== 9'd0 || vga_bus.err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_xy_err got x=%0d y=%0d err=%b expected 0/0/0",
                     vga_bus.x, vga_bus.y, vga_bus.err);
        end
        tests_run++;
        if (qvga_bus.in_ready !== 1'b1 || qvga_bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_qvga got in_ready=%b out_valid=%b expected 1/0",
                     qvga_bus.in_ready, qvga_bus.out_valid);
        end
        @(negedge clock);
        tests_run++;
        if (vga_bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_wins_over_in_valid got in_ready=%b expected 1", vga_bus.in_ready);
        end
    endtask

    task automatic test_zero_address;
        int lat;
        logic [9:0] ox;
        logic [8:0] oy;
        logic oerr;
        applyStimulus(1'b0, 19'd0, lat, ox, oy, oerr);
        tests_run++;
        if (lat !== 9) begin
            tests_failed++;
            $display("[TB] FAIL zero_latency got %0d expected 9", lat);
        end
        tests_run++;
        if (ox !== 10'd0 || oy !== 9'd0 || oerr !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero_result got x=%0d y=%0d err=%b expected 0/0/0", ox, oy, oerr);
        end
        tests_run++;
        if (vga_bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero_in_ready_in_done got %b expected 0", vga_bus.in_ready);
        end
        consumeResult(1'b0);
        tests_run++;
        if (vga_bus.out_valid !== 1'b0 || vga_bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL zero_consume got out_valid=%b in_ready=%b expected 0/1",
                     vga_bus.out_valid, vga_bus.in_ready);
        end
    endtask

    task automatic test_decode;
        int lat;
        logic [9:0] ox;
        logic [8:0] oy;
        logic oerr;
        logic [18:0] addrs [2] = '{19'd641, 19'd307199};
        logic [9:0]  exp_x [2] = '{10'd1, 10'd639};
        logic [8:0]  exp_y [2] = '{9'd1, 9'd479};
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, addrs[i], lat, ox, oy, oerr);
            tests_run++;
            if (lat !== 9) begin
                tests_failed++;
                $display("[TB] FAIL decode_latency addr=%0d got %0d expected 9", addrs[i], lat);
            end
            tests_run++;
            if (ox !== exp_x[i] || oy !== exp_y[i] || oerr !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL decode addr=%0d got x=%0d y=%0d err=%b expected %0d/%0d/0",
                         addrs[i], ox, oy, oerr, exp_x[i], exp_y[i]);
            end
            consumeResult(1'b0);
        end
    endtask

    task automatic test_error;
        int lat;
        logic [9:0] ox;
        logic [8:0] oy;
        logic oerr;
        logic [18:0] addrs [2] = '{19'd307200, 19'd524287};
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, addrs[i], lat, ox, oy, oerr);
            tests_run++;
            if (lat !== 0) begin
                tests_failed++;
                $display("[TB] FAIL error_latency addr=%0d got %0d expected 0", addrs[i], lat);
            end
            tests_run++;
            if (oerr !== 1'b1 || ox !== 10'd0 || oy !== 9'd0) begin
                tests_failed++;
                $display("[TB] FAIL error_result addr=%0d got x=%0d y=%0d err=%b expected 0/0/1",
                         addrs[i], ox, oy, oerr);
            end
            consumeResult(1'b0);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [9:0] ox;
        logic [8:0] oy;
        logic oerr;
        int bad;
        applyStimulus(1'b0, 19'd1279, lat, ox, oy, oerr);
        tests_run++;
        if (ox !== 10'd639 || oy !== 9'd1 || oerr !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_result got x=%0d y=%0d err=%b expected 639/1/0", ox, oy, oerr);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            vga_bus.in_valid    = 1'($urandom_range(0, 1));
            vga_bus.mem_address = 19'($urandom_range(0, 524287));
            @(posedge clock);
            @(negedge clock);
            if (vga_bus.out_valid !== 1'b1 || vga_bus.x !== 10'd639 || vga_bus.y !== 9'd1 ||
                vga_bus.in_ready !== 1'b0) begin
                bad++;
            end
        end
        vga_bus.in_valid = 1'b0;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold got %0d disturbed cycles expected 0", bad);
        end
        consumeResult(1'b0);
        tests_run++;
        if (vga_bus.out_valid !== 1'b0 || vga_bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_consume got out_valid=%b in_ready=%b expected 0/1",
                     vga_bus.out_valid, vga_bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_busy;
        int lat;
        logic [9:0] ox;
        logic [8:0] oy;
        logic oerr;
        int pulses;
        vga_bus.mem_address = 19'd200000;
        vga_bus.in_valid    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        vga_bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tests_run++;
        if (vga_bus.in_ready !== 1'b1 || vga_bus.out_valid !== 1'b0 || vga_bus.x !== 10'd0 ||
            vga_bus.y !== 9'd0 || vga_bus.err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_state got rdy=%b vld=%b x=%0d y=%0d err=%b expected 1/0/0/0/0",
                     vga_bus.in_ready, vga_bus.out_valid, vga_bus.x, vga_bus.y, vga_bus.err);
        end
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (vga_bus.out_valid !== 1'b0) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_no_pulse got %0d valid cycles expected 0", pulses);
        end
        applyStimulus(1'b0, 19'd200000, lat, ox, oy, oerr);
        tests_run++;
        if (lat !== 9 || ox !== 10'd320 || oy !== 9'd312 || oerr !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_redecode got lat=%0d x=%0d y=%0d err=%b expected 9/320/312/0",
                     lat, ox, oy, oerr);
        end
        consumeResult(1'b0);
    endtask

    task automatic test_qvga;
        int lat;
        logic [9:0] ox;
        logic [8:0] oy;
        logic oerr;
        applyStimulus(1'b1, 19'd76799, lat, ox, oy, oerr);
        tests_run++;
        if (lat !== 8 || ox !== 10'd319 || oy !== 9'd239 || oerr !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL qvga_last got lat=%0d x=%0d y=%0d err=%b expected 8/319/239/0",
                     lat, ox, oy, oerr);
        end
        consumeResult(1'b1);
        applyStimulus(1'b1, 19'd76800, lat, ox, oy, oerr);
        tests_run++;
        if (lat !== 0 || oerr !== 1'b1 || ox !== 10'd0 || oy !== 9'd0) begin
            tests_failed++;
            $display("[TB] FAIL qvga_error got lat=%0d x=%0d y=%0d err=%b expected 0/0/0/1",
                     lat, ox, oy, oerr);
        end
        consumeResult(1'b1);
    endtask

    // Reference model is plain mod/div on the address.
    task automatic test_random_sweep;
        int lat;
        logic [9:0] ox;
        logic [8:0] oy;
        logic oerr;
        logic [18:0] addr;
        logic [9:0] exp_x;
        logic [8:0] exp_y;
        logic exp_err;
        for (int n = 0; n < 1000; n++) begin
            addr = ($urandom_range(0, 7) == 0) ? 19'($urandom_range(307200, 524287))
                                              : 19'($urandom_range(0, 307199));
            exp_err = (addr >= 19'd307200);
            exp_x   = exp_err ? 10'd0 : 10'(addr % 640);
            exp_y   = exp_err ? 9'd0 : 9'(addr / 640);
            applyStimulus(1'b0, addr, lat, ox, oy, oerr);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock);
                @(negedge clock);
            end
            tests_run++;
            if (vga_bus.out_valid !== 1'b1 || vga_bus.x !== exp_x || vga_bus.y !== exp_y ||
                vga_bus.err !== exp_err) begin
                tests_failed++;
                $display("[TB] FAIL sweep addr=%0d got vld=%b x=%0d y=%0d err=%b expected 1/%0d/%0d/%b",
                         addr, vga_bus.out_valid, vga_bus.x, vga_bus.y, vga_bus.err,
                         exp_x, exp_y, exp_err);
            end
            consumeResult(1'b0);
        end
    endtask

    initial begin
        tests_run            = 0;
        tests_failed         = 0;
        reset                = 1'b1;
        vga_bus.mem_address  = '0;
        vga_bus.in_valid     = 1'b0;
        vga_bus.out_ready    = 1'b0;
        qvga_bus.mem_address = '0;
        qvga_bus.in_valid    = 1'b0;
        qvga_bus.out_ready   = 1'b0;
        @(negedge clock);
        test_reset();
        test_zero_address();
        test_decode();
        test_error();
        test_backpressure();
        test_reset_mid_busy();
        test_qvga();
        test_random_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
